// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle IF/ID/EXE/MEM/WB sequencer driving the MIPS datapath write enables.
// Optional macro MC_MEMWAIT_EN: MEM is held until the data memory raises MemReady.
module mc_control_fsm #(
  parameter int unsigned     OP_W    = 6,
  parameter logic [OP_W-1:0] HALT_OP = 6'h3F
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [OP_W-1:0] Opcode,
  input  logic            MemReady,
  output logic [2:0]      State,
  output logic            PCWre,
  output logic            IRWre,
  output logic            RegWre,
  output logic            mRD,
  output logic            mWR
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'h0D);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2B);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'h05);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'h03);

  state_t state_q, state_d;

  logic is_halt, is_lw, is_sw, is_jal, is_jump, is_br, is_alu, is_mem, is_illegal;
  logic mem_done;
  logic pc_wre, ir_wre, reg_wre, mem_rd, mem_wr;

  assign is_halt    = (Opcode == HALT_OP);
  assign is_lw      = (Opcode == OP_LW);
  assign is_sw      = (Opcode == OP_SW);
  assign is_jal     = (Opcode == OP_JAL);
  assign is_jump    = (Opcode == OP_J) | is_jal;
  assign is_br      = (Opcode == OP_BEQ) | (Opcode == OP_BNE);
  assign is_alu     = (Opcode == OP_R) | (Opcode == OP_ADDI) | (Opcode == OP_ORI);
  assign is_mem     = is_lw | is_sw;
  assign is_illegal = ~(is_halt | is_jump | is_br | is_alu | is_mem);

`ifdef MC_MEMWAIT_EN
  assign mem_done = MemReady;
`else
  // Without the wait option MEM always completes in one cycle.
  logic unused_memready;
  assign unused_memready = MemReady;
  assign mem_done        = 1'b1;
`endif

  // NOTE: only the state register is reset; it is the sole storage element here.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (RST) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    pc_wre  = 1'b0;
    ir_wre  = 1'b0;
    reg_wre = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      S_IF: begin
        ir_wre  = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_jump | is_illegal) begin
          state_d = S_IF;
          pc_wre  = 1'b1;
          reg_wre = is_jal;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_br) begin
          state_d = S_IF;
          pc_wre  = 1'b1;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Strobes stay up for the whole access; the store retires only once memory is done.
        mem_rd = is_lw;
        mem_wr = is_sw;
        pc_wre = is_sw & mem_done;
        if (mem_done) state_d = is_sw ? S_IF : S_WB;
      end
      S_WB: begin
        reg_wre = 1'b1;
        pc_wre  = 1'b1;
        state_d = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Reset masks every enable combinationally so the datapath sees a clean idle CPU.
  assign State  = RST ? S_IF : state_q;
  assign PCWre  = pc_wre  & ~RST;
  assign IRWre  = ir_wre  & ~RST;
  assign RegWre = reg_wre & ~RST;
  assign mRD    = mem_rd  & ~RST;
  assign mWR    = mem_wr  & ~RST;

endmodule
